// File: rtl/bcd_time_counter.sv
// 24-hour HH:MM:SS BCD time-of-day counter with 1 Hz prescaler,
// validated load, and a six-digit multiplexed BCD scan output.
module bcd_time_counter #(
   parameter int TICK_DIV = 50_000_000,
   parameter int SCAN_DIV = 50_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        run,
   input  logic        load,
   input  logic [23:0] load_bcd,
   output logic [3:0]  hour_t,
   output logic [3:0]  hour_u,
   output logic [3:0]  min_t,
   output logic [3:0]  min_u,
   output logic [3:0]  sec_t,
   output logic [3:0]  sec_u,
   output logic [3:0]  digit_bcd,
   output logic [5:0]  digit_sel,
   output logic        sec_pulse,
   output logic        day_pulse,
   output logic        load_err
);

   localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [PW-1:0] P_MAX = PW'(TICK_DIV - 1);
   localparam logic [SW-1:0] S_MAX = SW'(SCAN_DIV - 1);

   // index 0 = sec_u ... index 5 = hour_t
   logic [5:0][3:0] time_q, time_d, time_inc, lb;
   logic [PW-1:0]   presc_q, presc_d;
   logic [SW-1:0]   scan_q, scan_d;
   logic [2:0]      idx_q, idx_d;
   logic [5:0]      sel_q, sel_d;
   logic [3:0]      bcd_q, bcd_d;
   logic            sp_q, sp_d;
   logic            dp_q, dp_d;
   logic            err_q, err_d;
   logic            tick, load_ok, wrap_day;

   assign lb = load_bcd;

   always_comb begin
      load_ok = 1'b1;
      for (int i = 0; i < 6; i++) begin
         if (lb[i] > 4'd9) load_ok = 1'b0;
      end
      if (lb[1] > 4'd5) load_ok = 1'b0;
      if (lb[3] > 4'd5) load_ok = 1'b0;
      if (lb[5] > 4'd2) load_ok = 1'b0;
      if (lb[5] == 4'd2 && lb[4] > 4'd3) load_ok = 1'b0;
   end

   always_comb begin
      time_inc = time_q;
      wrap_day = 1'b0;
      if (time_q[0] != 4'd9) begin
         time_inc[0] = time_q[0] + 4'd1;
      end else begin
         time_inc[0] = 4'd0;
         if (time_q[1] != 4'd5) begin
            time_inc[1] = time_q[1] + 4'd1;
         end else begin
            time_inc[1] = 4'd0;
            if (time_q[2] != 4'd9) begin
               time_inc[2] = time_q[2] + 4'd1;
            end else begin
               time_inc[2] = 4'd0;
               if (time_q[3] != 4'd5) begin
                  time_inc[3] = time_q[3] + 4'd1;
               end else begin
                  time_inc[3] = 4'd0;
                  if (time_q[5] == 4'd2 && time_q[4] == 4'd3) begin
                     time_inc[5] = 4'd0;
                     time_inc[4] = 4'd0;
                     wrap_day    = 1'b1;
                  end else if (time_q[4] == 4'd9) begin
                     time_inc[4] = 4'd0;
                     time_inc[5] = time_q[5] + 4'd1;
                  end else begin
                     time_inc[4] = time_q[4] + 4'd1;
                  end
               end
            end
         end
      end
   end

   always_comb begin
      tick    = run && (presc_q == P_MAX);
      time_d  = time_q;
      presc_d = presc_q;
      sp_d    = 1'b0;
      dp_d    = 1'b0;
      err_d   = 1'b0;
      if (load && load_ok) begin
         time_d  = lb;
         presc_d = '0;
      end else begin
         err_d = load;
         if (tick) begin
            presc_d = '0;
            time_d  = time_inc;
            sp_d    = 1'b1;
            dp_d    = wrap_day;
         end else if (run) begin
            presc_d = presc_q + 1'b1;
         end
      end
   end

   always_comb begin
      scan_d = (scan_q == S_MAX) ? '0 : scan_q + 1'b1;
      idx_d  = idx_q;
      if (scan_q == S_MAX) begin
         idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
      end
      sel_d = 6'b000001 << idx_d;
      case (idx_d)
         3'd0:    bcd_d = time_q[0];
         3'd1:    bcd_d = time_q[1];
         3'd2:    bcd_d = time_q[2];
         3'd3:    bcd_d = time_q[3];
         3'd4:    bcd_d = time_q[4];
         3'd5:    bcd_d = time_q[5];
         default: bcd_d = 4'd0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         time_q  <= '0;
         presc_q <= '0;
         scan_q  <= '0;
         idx_q   <= '0;
         sel_q   <= 6'b000001;
         bcd_q   <= '0;
         sp_q    <= 1'b0;
         dp_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         time_q  <= time_d;
         presc_q <= presc_d;
         scan_q  <= scan_d;
         idx_q   <= idx_d;
         sel_q   <= sel_d;
         bcd_q   <= bcd_d;
         sp_q    <= sp_d;
         dp_q    <= dp_d;
         err_q   <= err_d;
      end
   end

   assign sec_u     = time_q[0];
   assign sec_t     = time_q[1];
   assign min_u     = time_q[2];
   assign min_t     = time_q[3];
   assign hour_u    = time_q[4];
   assign hour_t    = time_q[5];
   assign digit_sel = sel_q;
   assign digit_bcd = bcd_q;
   assign sec_pulse = sp_q;
   assign day_pulse = dp_q;
   assign load_err  = err_q;

endmodule

// File: tb/tb_bcd_time_counter.sv
// Bench for bcd_time_counter: seconds-of-day reference model compared
// every cycle, directed scenarios with literal expectations, random run/load.
module tb_bcd_time_counter;

   localparam int TD = 4;
   localparam int SD = 2;

   logic        clk;
   logic        rst;
   logic        run;
   logic        load;
   logic [23:0] load_bcd;
   logic [3:0]  hour_t, hour_u, min_t, min_u, sec_t, sec_u;
   logic [3:0]  digit_bcd;
   logic [5:0]  digit_sel;
   logic        sec_pulse, day_pulse, load_err;

   bcd_time_counter #(.TICK_DIV(TD), .SCAN_DIV(SD)) dut (
      .clk(clk), .rst(rst), .run(run), .load(load), .load_bcd(load_bcd),
      .hour_t(hour_t), .hour_u(hour_u), .min_t(min_t), .min_u(min_u),
      .sec_t(sec_t), .sec_u(sec_u), .digit_bcd(digit_bcd),
      .digit_sel(digit_sel), .sec_pulse(sec_pulse),
      .day_pulse(day_pulse), .load_err(load_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_err    = 0;
   bit started  = 0;

   wire [23:0] tnow = {hour_t, hour_u, min_t, min_u, sec_t, sec_u};

   task automatic chk(input string nm, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int dec(input logic [23:0] b);
      return (b[23:20] * 10 + b[19:16]) * 3600 +
             (b[15:12] * 10 + b[11:8]) * 60 + b[7:4] * 10 + b[3:0];
   endfunction

   function automatic bit valid(input logic [23:0] b);
      int ht, hu, mt, mu, st, su;
      ht = b[23:20]; hu = b[19:16]; mt = b[15:12];
      mu = b[11:8];  st = b[7:4];   su = b[3:0];
      if (ht > 9 || hu > 9 || mt > 9 || mu > 9 || st > 9 || su > 9) return 0;
      return (ht * 10 + hu < 24) && mt <= 5 && st <= 5;
   endfunction

   function automatic int digit(input int tod, input int i);
      int h, m, s;
      h = tod / 3600; m = (tod / 60) % 60; s = tod % 60;
      case (i)
         0: return s % 10;
         1: return s / 10;
         2: return m % 10;
         3: return m / 10;
         4: return h % 10;
         default: return h / 10;
      endcase
   endfunction

   function automatic logic [23:0] enc(input int tod);
      logic [23:0] r;
      r = '0;
      for (int i = 0; i < 6; i++) r[i*4 +: 4] = 4'(digit(tod, i));
      return r;
   endfunction

   // reference model: time as seconds of day, prescaler as plain count
   int       m_tod, m_p, m_n;
   bit       m_sp, m_dp, m_err;
   int       m_bcd;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_tod <= 0; m_p <= 0; m_n <= 0;
         m_sp <= 0; m_dp <= 0; m_err <= 0; m_bcd <= 0;
      end else begin
         if (load && valid(load_bcd)) begin
            m_tod <= dec(load_bcd);
            m_p <= 0; m_sp <= 0; m_dp <= 0; m_err <= 0;
         end else begin
            m_err <= load;
            if (run && m_p == TD - 1) begin
               m_p   <= 0;
               m_tod <= (m_tod + 1) % 86400;
               m_sp  <= 1;
               m_dp  <= (m_tod == 86399);
            end else begin
               m_sp <= 0;
               m_dp <= 0;
               if (run) m_p <= m_p + 1;
            end
         end
         m_n   <= m_n + 1;
         m_bcd <= digit(m_tod, ((m_n + 1) / SD) % 6);
      end
   end

   always @(negedge clk) begin
      if (started && !rst) begin
         chk("m_sec_u", sec_u, digit(m_tod, 0));
         chk("m_sec_t", sec_t, digit(m_tod, 1));
         chk("m_min_u", min_u, digit(m_tod, 2));
         chk("m_min_t", min_t, digit(m_tod, 3));
         chk("m_hour_u", hour_u, digit(m_tod, 4));
         chk("m_hour_t", hour_t, digit(m_tod, 5));
         chk("m_digit_sel", digit_sel, 1 << ((m_n / SD) % 6));
         chk("m_digit_bcd", digit_bcd, m_bcd);
         chk("m_sec_pulse", sec_pulse, m_sp);
         chk("m_day_pulse", day_pulse, m_dp);
         chk("m_load_err", load_err, m_err);
      end
   end

   task automatic step();
      @(negedge clk);
   endtask

   task automatic do_load(input logic [23:0] v);
      load = 1'b1;
      load_bcd = v;
      step();
      load = 1'b0;
   endtask

   task automatic wait_pulse(input int max, input string nm);
      bit found;
      found = 0;
      for (int k = 0; k < max && !found; k++) begin
         step();
         if (sec_pulse) found = 1;
      end
      chk(nm, found, 1);
   endtask

   int np, first, last, k, tbl[6];
   bit found;

   initial begin
      run = 0; load = 0; load_bcd = '0; rst = 0;
      tbl = '{6, 5, 4, 3, 2, 1};
      #1 rst = 1;
      started = 1;
      repeat (2) step();
      chk("rst_time", tnow, 0);
      chk("rst_sel", digit_sel, 1);
      chk("rst_bcd", digit_bcd, 0);
      chk("rst_pulses", {sec_pulse, day_pulse, load_err}, 0);
      rst = 0;

      // free run: 40 cycles -> 10 ticks, 4 cycles apart
      run = 1; np = 0; first = -1; last = -1;
      for (int c = 1; c <= 40; c++) begin
         step();
         if (sec_pulse) begin
            np++;
            if (first < 0) first = c;
            last = c;
         end
      end
      chk("run40_pulses", np, 10);
      chk("run40_spacing", last - first, 36);
      chk("run40_time", tnow, 24'h000010);

      // day wrap
      do_load(24'h235959);
      wait_pulse(8, "wrap_timeout");
      chk("wrap_time", tnow, 0);
      chk("wrap_day", day_pulse, 1);
      step();
      chk("wrap_day_end", day_pulse, 0);
      chk("wrap_sp_end", sec_pulse, 0);

      // hour carries
      do_load(24'h095959);
      wait_pulse(8, "h10_timeout");
      chk("h10_time", tnow, 24'h100000);
      do_load(24'h195959);
      wait_pulse(8, "h20_timeout");
      chk("h20_time", tnow, 24'h200000);
      run = 0;

      // rejected loads
      do_load(24'h240000);
      chk("bad24_err", load_err, 1);
      chk("bad24_time", tnow, 24'h200000);
      do_load(24'h126000);
      chk("bad60_err", load_err, 1);
      chk("bad60_time", tnow, 24'h200000);
      do_load(24'h123A00);
      chk("bad3A_err", load_err, 1);
      chk("bad3A_time", tnow, 24'h200000);
      step();
      chk("err_end", load_err, 0);
      do_load(24'h123456);
      chk("good_err", load_err, 0);
      chk("good_time", tnow, 24'h123456);

      // load on the tick edge
      run = 1;
      do_load(24'h010203);
      repeat (3) step();
      do_load(24'h111111);
      chk("lt_time", tnow, 24'h111111);
      chk("lt_nopulse", sec_pulse, 0);
      found = 0; k = 0;
      while (!found && k < 10) begin
         step(); k++;
         if (sec_pulse) found = 1;
      end
      chk("lt_next_pulse", k, 4);

      // scan walk with time frozen
      run = 0;
      do_load(24'h123456);
      found = 0; k = 0;
      while (!found && k < 30) begin
         step(); k++;
         if (digit_sel == 6'b100000) found = 1;
      end
      chk("scan_sync5", found, 1);
      found = 0; k = 0;
      while (!found && k < 30) begin
         step(); k++;
         if (digit_sel == 6'b000001) found = 1;
      end
      chk("scan_sync0", found, 1);
      for (int c = 0; c < 12; c++) begin
         chk("scan_sel", digit_sel, 1 << (c / 2));
         chk("scan_bcd", digit_bcd, tbl[c / 2]);
         step();
      end

      // asynchronous reset mid-frame
      step();
      @(posedge clk);
      #2 rst = 1;
      #1;
      chk("arst_time", tnow, 0);
      chk("arst_sel", digit_sel, 1);
      chk("arst_bcd", digit_bcd, 0);
      step();
      rst = 0;

      // random run/load traffic against the model
      for (int c = 0; c < 3000; c++) begin
         run  = ($urandom_range(3) != 0);
         load = ($urandom_range(7) == 0);
         if ($urandom_range(1) == 0)
            load_bcd = enc($urandom_range(86399));
         else
            load_bcd = 24'($urandom);
         if ($urandom_range(499) == 0) begin
            #2 rst = 1;
            #2 rst = 0;
         end
         step();
      end
      load = 0;
      run = 0;
      step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
